// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared fetch-stage state encoding and constants
package if_fetch_stage_pkg;

  // Fetch FSM states: request outstanding, instruction held, stale request being dropped
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with req/ack imem handshake and redirect drop
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] IF_PC,
  output logic [ADDR_W-1:0] IF_ins,
  output logic              IF_valid,
  output logic              IFflush
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_ins;
  logic              r_if_valid;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_seq_pc;

  // Redirect target is word aligned; sequential next address wraps naturally at 2^32
  always_comb begin
    w_target = redirect_pc & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    w_seq_pc = r_req_addr + {{(ADDR_W-3){1'b0}}, 3'd4};
  end

  // Request and flush are suppressed while reset is asserted
  always_comb begin
    imem_req  = ((r_state == S_REQ) || (r_state == S_DROP)) && !rst;
    imem_addr = r_req_addr;
    IFflush   = redirect_en && !rst;
    IF_PC     = r_if_pc;
    IF_ins    = r_if_ins;
    IF_valid  = r_if_valid;
  end

  // Fetch FSM: redirect beats ack and PCWrite; the address stays put while a request is unacked
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_req_addr <= RESET_PC;
      r_pend_pc  <= RESET_PC;
      r_if_pc    <= RESET_PC;
      r_if_ins   <= INSTR_NOP;
      r_if_valid <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect_en) begin
            r_if_valid <= 1'b0;
            if (imem_ack) begin
              r_req_addr <= w_target;
            end else begin
              r_pend_pc <= w_target;
              r_state   <= S_DROP;
            end
          end else if (imem_ack) begin
            r_if_ins   <= imem_rdata;
            r_if_pc    <= r_req_addr;
            r_if_valid <= 1'b1;
            r_state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (redirect_en) begin
            r_if_valid <= 1'b0;
            r_req_addr <= w_target;
            r_state    <= S_REQ;
          end else if (PCWrite) begin
            r_if_valid <= 1'b0;
            r_req_addr <= w_seq_pc;
            r_state    <= S_REQ;
          end
        end
        S_DROP: begin
          r_if_valid <= 1'b0;
          if (redirect_en) begin
            r_pend_pc <= w_target;
            if (imem_ack) begin
              r_req_addr <= w_target;
              r_state    <= S_REQ;
            end
          end else if (imem_ack) begin
            r_req_addr <= r_pend_pc;
            r_state    <= S_REQ;
          end
        end
        default: begin
          r_state    <= S_REQ;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues requests to instruction memory over a req/ack handshake.
- Holds the fetched instruction and its fetch address (IF_PC, IF_ins) stable for IF/ID. IF/ID computes PC+4 itself.
- Honours stall (PCWrite) and branch/jump redirect from ID, discarding stale memory responses.

Parameters:
RESET_PC, 32'h0000_3000, first fetch address after reset
ADDR_W, 32, address/data width (fixed at 32 for this design)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
PCWrite  input  1  1 = advance to next PC once held instruction consumed; 0 = stall
redirect_en  input  1  branch/jump taken in ID; overrides sequential fetch
redirect_pc  input  32  redirect target
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  input  1  memory response valid this cycle (only sampled while imem_req=1)
imem_rdata  input  32  instruction word, valid with imem_ack
IF_PC  output  32  address of held instruction
IF_ins  output  32  held instruction word
IF_valid  output  1  IF_PC/IF_ins hold a live instruction
IFflush  output  1  combinational = redirect_en & ~rst; drives IF/ID flush

Behaviour:
- Internal regs: state, req_addr[31:0] (outstanding/next fetch address), pend_pc[31:0] (redirect target parked during drop).
- States: S_REQ (request outstanding), S_HOLD (instruction held, no request), S_DROP (stale request outstanding, response to be discarded).
- Reset (rst=1 at edge): state=S_REQ, req_addr=RESET_PC, pend_pc=RESET_PC, IF_PC=RESET_PC, IF_ins=0, IF_valid=0. imem_req=0 during any cycle rst=1. imem is reset by the same rst, so no ack from a pre-reset request can arrive.
- imem_req = (state==S_REQ || state==S_DROP) & ~rst. imem_addr = req_addr.
- Redirect target: redirect_pc with bits[1:0] forced to 00.
- S_REQ, no redirect:
  - imem_ack=1 -> IF_ins<=imem_rdata, IF_PC<=req_addr, IF_valid<=1, go S_HOLD.
  - Otherwise stay; req_addr is unchanged.
- S_HOLD, no redirect:
  - PCWrite=1 -> req_addr<=req_addr+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), IF_valid<=0, go S_REQ.
  - PCWrite=0 -> hold everything.
- Latency: 1 cycle from ack to IF_valid. With zero-wait memory (ack in the same cycle as req), throughput is one instruction per 2 cycles.
- Redirect (redirect_en=1), priority above PCWrite and imem_ack; IF_valid<=0 in all cases:
  - S_HOLD -> req_addr<=target, go S_REQ.
  - S_REQ with imem_ack=1 -> data discarded, req_addr<=target, go S_REQ.
  - S_REQ with imem_ack=0 -> pend_pc<=target, go S_DROP. req_addr is unchanged because the handshake requires a stable address.
  - S_DROP -> pend_pc<=target (latest redirect wins). If imem_ack=1 the same cycle, req_addr<=target and go S_REQ directly.
- S_DROP, no redirect: on imem_ack, discard data, req_addr<=pend_pc, go S_REQ. IF_valid stays 0.
- Redirect + PCWrite=0 simultaneously: redirect wins and the stall is ignored for that edge.
- rst mid-transaction: immediate return to reset values; any pending or drop context is lost.
- IF_PC/IF_ins change only on capture. IF_ins keeps its last value when IF_valid=0.

Decomposition:
- Shared pipeline package holds:
  - the state encoding localparams S_REQ=2'd0, S_HOLD=2'd1, S_DROP=2'd2;
  - RESET_PC default 32'h0000_3000;
  - INSTR_NOP=32'h0000_0000.
- No sub-module. The next-PC adder and target select stay inline; the block is a single module.

Test Plan:
- Reset then zero-wait memory (ack every req cycle), PCWrite=1 -> imem_addr sequence 0x3000, 0x3004, 0x3008. IF_valid pulses 1 cycle after each ack with IF_PC matching the address.
- Ack arrives 3 cycles late for 0x3000 -> imem_addr held at 0x3000 for all 4 request cycles. IF_ins=rdata (e.g. 0x2408_0005) and IF_valid=1 the following cycle.
- Instruction held, PCWrite=0 for 4 cycles -> imem_req=0 and IF_PC/IF_ins/IF_valid unchanged. PCWrite=1 -> next imem_addr=IF_PC+4.
- S_REQ at 0x3008 with no ack, redirect_en=1 with redirect_pc=0x3043 -> IFflush=1 that cycle, address held at 0x3008 until ack. That ack's data is not captured. Next request is at 0x3040.
- Redirect and PCWrite=0 in S_HOLD at IF_PC=0x3010, redirect_pc=0x3100 -> IF_valid=0 and next imem_addr=0x3100.
- req_addr=0xFFFF_FFFC captured, PCWrite=1 -> next imem_addr=0x0000_0000. rst asserted while in S_DROP -> next request is at 0x3000 with IF_valid=0.
